// File: rtl/inst_prefetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_prefetch_queue_pkg
//   Shared definitions for the instruction prefetch queue:
//   - fetch_state_e : fetch FSM encoding (REQ / WAIT / DROP)
//   - default queue depth and reset fetch address
//   - fetch_entry_t : one queue entry {pc, inst}
//   - helpers for PC alignment and sequential PC advance
// -----------------------------------------------------------------------------
package inst_prefetch_queue_pkg;

   // REQ : free to issue a fetch
   // WAIT: a fetch is outstanding and its data will be kept
   // DROP: a fetch is outstanding but a redirect made its data stale
   typedef enum logic [1:0] {
      ST_REQ  = 2'b00,
      ST_WAIT = 2'b01,
      ST_DROP = 2'b10
   } fetch_state_e;

   localparam int          IPQ_DEFAULT_DEPTH    = 4;
   localparam logic [31:0] IPQ_DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // Instructions are word aligned; the two low address bits are forced to 0.
   function automatic logic [31:0] ipq_align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

   // Sequential advance; wraps 0xFFFF_FFFC -> 0x0000_0000 by 32-bit overflow.
   function automatic logic [31:0] ipq_next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO holding fetched {pc, inst} entries. The head entry is
//   kept in its own register so the consumer sees a registered value that is
//   never a combinational path from the write data.
//   DEPTH must be a power of two, at least 2 (pointers wrap by overflow).
//   Ports: clk, rst      - clock / synchronous active-high reset
//          clear_i       - drop all entries (has priority over push/pop)
//          push_i        - write push_data_i at the tail
//          push_data_i   - entry to write
//          pop_i         - remove the head (ignored when empty)
//          count_o       - number of valid entries
//          head_o        - registered copy of the head entry
// -----------------------------------------------------------------------------
module fetch_fifo
   import inst_prefetch_queue_pkg::*;
#(
   parameter  int DEPTH = IPQ_DEFAULT_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             push_i,
   input  fetch_entry_t     push_data_i,
   input  logic             pop_i,
   output logic [CNT_W-1:0] count_o,
   output fetch_entry_t     head_o
);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] remain_s;
   fetch_entry_t     head_q, head_d;
   logic             pop_s;
   logic             write_s;

   // Next pointers, occupancy and head register value.
   always_comb begin
      pop_s    = pop_i && (count_q != {CNT_W{1'b0}});
      write_s  = push_i && !clear_i;
      remain_s = count_q - CNT_W'(pop_s);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (clear_i) begin
         rd_ptr_d = {PTR_W{1'b0}};
         wr_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
         wr_ptr_d = wr_ptr_q + PTR_W'(write_s);
         count_d  = remain_s + CNT_W'(write_s);
         // If the queue is empty after the pop, the new head is the entry
         // being written now; otherwise it is already in storage.
         if (write_s && (remain_s == {CNT_W{1'b0}})) begin
            head_d = push_data_i;
         end else if (remain_s != {CNT_W{1'b0}}) begin
            head_d = mem_q[rd_ptr_d];
         end else begin
            head_d = head_q;
         end
      end
   end

   // Storage, pointers, occupancy and head register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= {PTR_W{1'b0}};
         wr_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         head_q   <= {$bits(fetch_entry_t){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {$bits(fetch_entry_t){1'b0}};
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         if (write_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
         end
      end
   end

   assign count_o = count_q;
   assign head_o  = head_q;

   fetch_fifo_chk #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_chk (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear_i),
      .push_i  (push_i),
      .count_i (count_q)
   );

endmodule

// File: rtl/fetch_fifo_chk.sv
// -----------------------------------------------------------------------------
// fetch_fifo_chk
//   Assertion checker bound into fetch_fifo. Flags a push into a full queue
//   and an occupancy count outside 0..DEPTH.
//   Ports: clk, rst      - clock / synchronous active-high reset
//          clear_i       - flush request (a push is suppressed while set)
//          push_i        - enqueue request
//          count_i       - current occupancy
// -----------------------------------------------------------------------------
module fetch_fifo_chk #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [CNT_W-1:0] count_i
);

   // The fetch FSM never requests when full, so an overflowing push means
   // the request throttle is broken.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push_i && !clear_i && (count_i == CNT_W'(DEPTH))))
      else $error("fetch_fifo: push into a full queue");

   a_count_range: assert property (@(posedge clk) disable iff (rst)
      count_i <= CNT_W'(DEPTH))
      else $error("fetch_fifo: occupancy above DEPTH");

endmodule

// File: rtl/inst_prefetch_queue.sv
// -----------------------------------------------------------------------------
// inst_prefetch_queue
//   Instruction prefetch queue between an instruction memory and the IF/ID
//   register. A three-state FSM (REQ/WAIT/DROP) issues sequential fetches
//   while the queue has room, pushes returned instructions into fetch_fifo
//   and discards the data of a fetch overtaken by a redirect.
//   Parameters: DEPTH    - queue entries (power of two, >= 2)
//               RESET_PC - first fetch address after reset
//   Ports: clk, rst            - clock / synchronous active-high reset
//          redirect, redirect_pc - flush queue and restart fetch at redirect_pc
//          imem_req, imem_addr - fetch request / word-aligned address
//          imem_ack, imem_rdata - fetch completion / returned instruction
//          deq_valid, deq_pc, deq_inst - registered head of the queue
//          deq_ready           - consumer takes the head this cycle
// -----------------------------------------------------------------------------
module inst_prefetch_queue
   import inst_prefetch_queue_pkg::*;
#(
   parameter int          DEPTH    = IPQ_DEFAULT_DEPTH,
   parameter logic [31:0] RESET_PC = IPQ_DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        deq_valid,
   output logic [31:0] deq_pc,
   output logic [31:0] deq_inst,
   input  logic        deq_ready
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_e     state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      drop_addr_q, drop_addr_d;
   logic [CNT_W-1:0] count_s;
   logic             req_s;
   logic             ack_s;
   logic             push_s;
   logic             pop_s;
   logic             valid_s;
   fetch_entry_t     push_data_s;
   fetch_entry_t     head_s;

   // Memory handshake and queue push/pop qualification.
   // The request depends only on registered state (and rst), so a zero-wait
   // memory may ack in the same cycle without a combinational loop.
   always_comb begin
      valid_s = !rst && (count_s != {CNT_W{1'b0}});
      case (state_q)
         ST_REQ:  req_s = (count_s < CNT_W'(DEPTH));
         ST_WAIT: req_s = 1'b1;
         ST_DROP: req_s = 1'b1;
         default: req_s = 1'b0;
      endcase
      req_s  = req_s && !rst;
      ack_s  = req_s && imem_ack;
      // A redirect flushes the queue, so it overrides both push and pop.
      push_s = ack_s && (state_q != ST_DROP) && !redirect;
      pop_s  = valid_s && deq_ready && !redirect;
      push_data_s.pc   = fetch_pc_q;
      push_data_s.inst = imem_rdata;
   end

   // Fetch FSM next state and fetch address bookkeeping.
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      drop_addr_d = drop_addr_q;
      if (redirect) begin
         fetch_pc_d = ipq_align_pc(redirect_pc);
      end else if (push_s) begin
         fetch_pc_d = ipq_next_pc(fetch_pc_q);
      end else begin
         fetch_pc_d = fetch_pc_q;
      end
      case (state_q)
         ST_REQ: begin
            if (req_s && !imem_ack) begin
               // The request is visible to memory and must be held; if a
               // redirect arrives now its data will be stale.
               if (redirect) begin
                  state_d     = ST_DROP;
                  drop_addr_d = fetch_pc_q;
               end else begin
                  state_d = ST_WAIT;
               end
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (ack_s) begin
               state_d = ST_REQ;
            end else if (redirect) begin
               state_d     = ST_DROP;
               drop_addr_d = fetch_pc_q;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DROP: begin
            // fetch_pc already holds the newest redirect target, so a further
            // redirect here only updates fetch_pc and the drop continues.
            if (ack_s) begin
               state_d = ST_REQ;
            end else begin
               state_d = ST_DROP;
            end
         end
         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   // FSM state and fetch address registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_REQ;
         fetch_pc_q  <= RESET_PC;
         drop_addr_q <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         drop_addr_q <= drop_addr_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (redirect),
      .push_i      (push_s),
      .push_data_i (push_data_s),
      .pop_i       (pop_s),
      .count_o     (count_s),
      .head_o      (head_s)
   );

   // While dropping, the memory still serves the old address until its ack.
   assign imem_req  = req_s;
   assign imem_addr = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;
   assign deq_valid = valid_s;
   assign deq_pc    = head_s.pc;
   assign deq_inst  = head_s.inst;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_prefetch_queue
//   Self-checking bench for inst_prefetch_queue: a vector table, directed
//   corner-case sequences and random stimulus, all compared every cycle
//   against a queue-based behavioural model.
// -----------------------------------------------------------------------------
module tb_inst_prefetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          NV       = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        deq_valid;
   logic [31:0] deq_pc;
   logic [31:0] deq_inst;
   logic        deq_ready;

   always #5 clk = ~clk;

   inst_prefetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .deq_valid   (deq_valid),
      .deq_pc      (deq_pc),
      .deq_inst    (deq_inst),
      .deq_ready   (deq_ready)
   );

   // Instruction memory content: a fixed scramble of the address.
   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
   endfunction

   assign imem_rdata = inst_of(imem_addr);

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- memory responder ----------------
   int ack_mode  = 0;   // 0: ack_force, 1: fixed latency, 2: random
   bit ack_force = 1'b1;
   int ack_lat   = 0;
   int req_age   = 0;

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_next_pc     = 32'h0000_0000;
   logic [31:0] m_out_addr    = 32'h0000_0000;
   bit          m_outstanding = 1'b0;
   bit          m_discard     = 1'b0;

   // samples of the most recent cycle
   logic        s_rst, s_redir, s_ready, s_ack, s_req, s_valid;
   logic [31:0] s_rpc, s_addr, s_pc, s_inst;

   task automatic do_cycle();
      logic        e_req;
      logic        e_valid;
      logic [31:0] e_addr;
      ent_t        e;
      #1;
      case (ack_mode)
         0:       imem_ack = ack_force;
         1:       imem_ack = imem_req && (req_age >= ack_lat);
         default: imem_ack = ($urandom_range(0, 1) == 0);
      endcase
      #1;
      s_rst = rst;  s_redir = redirect; s_rpc = redirect_pc; s_ready = deq_ready;
      s_ack = imem_ack; s_req = imem_req; s_addr = imem_addr;
      s_valid = deq_valid; s_pc = deq_pc; s_inst = deq_inst;

      e_req   = !s_rst && (m_outstanding || (mq.size() < DEPTH));
      e_addr  = m_outstanding ? m_out_addr : m_next_pc;
      e_valid = !s_rst && (mq.size() != 0);
      chk("model_req", s_req, e_req);
      if (e_req) chk("model_addr", s_addr, e_addr);
      chk("model_valid", s_valid, e_valid);
      if (e_valid) begin
         chk("model_deq_pc", s_pc, mq[0].pc);
         chk("model_deq_inst", s_inst, mq[0].inst);
      end

      if (s_rst) begin
         mq.delete();
         m_outstanding = 1'b0;
         m_discard     = 1'b0;
         m_next_pc     = RESET_PC;
      end else if (s_redir) begin
         mq.delete();
         if (e_req && !s_ack) begin
            m_outstanding = 1'b1;
            m_discard     = 1'b1;
            m_out_addr    = e_addr;
         end else begin
            m_outstanding = 1'b0;
            m_discard     = 1'b0;
         end
         m_next_pc = {s_rpc[31:2], 2'b00};
      end else begin
         if (e_valid && s_ready) void'(mq.pop_front());
         if (e_req && s_ack) begin
            if (!m_discard) begin
               e.pc   = e_addr;
               e.inst = inst_of(e_addr);
               mq.push_back(e);
               m_next_pc = e_addr + 32'd4;
            end
            m_outstanding = 1'b0;
            m_discard     = 1'b0;
         end else if (e_req) begin
            m_outstanding = 1'b1;
            m_out_addr    = e_addr;
         end
      end

      if (s_rst || !s_req || s_ack) req_age = 0;
      else req_age++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0000_0000; deq_ready = 1'b0;
      do_cycle();
      rst = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] rpc;
      logic        ready;
      logic        ack;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vt[NV];

   function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rp,
                               input logic rdy, input logic ak, input logic eq,
                               input logic [31:0] ea, input logic ev, input logic [31:0] ep);
      vec_t v;
      v.rst = r; v.redir = rd; v.rpc = rp; v.ready = rdy; v.ack = ak;
      v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          found, got_deq, got_addr;
      logic [31:0] first_addr, first_pc;

      rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0000_0000;
      deq_ready = 1'b0; imem_ack = 1'b0;

      // Fill with backpressure, drain in order, then redirect to an unaligned
      // address near the top of the address space to check alignment/wrap.
      vt[0]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);
      vt[1]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         1'b0, 32'h0);
      vt[2]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h4,         1'b1, 32'h0);
      vt[3]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h8,         1'b1, 32'h0);
      vt[4]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hC,         1'b1, 32'h0);
      vt[5]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0);
      vt[6]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0);
      vt[7]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h10,        1'b1, 32'h4);
      vt[8]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h14,        1'b1, 32'h8);
      vt[9]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h18,        1'b1, 32'hC);
      vt[10] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC);
      vt[11] = mk(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC);
      vt[12] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      vt[13] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC);
      vt[14] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h4,         1'b1, 32'h0);

      ack_mode = 0;
      for (int i = 0; i < NV; i++) begin
         rst = vt[i].rst; redirect = vt[i].redir; redirect_pc = vt[i].rpc;
         deq_ready = vt[i].ready; ack_force = vt[i].ack;
         do_cycle();
         chk($sformatf("vec%0d_req", i), s_req, vt[i].e_req);
         if (vt[i].e_req) chk($sformatf("vec%0d_addr", i), s_addr, vt[i].e_addr);
         chk($sformatf("vec%0d_valid", i), s_valid, vt[i].e_valid);
         if (vt[i].e_valid) begin
            chk($sformatf("vec%0d_pc", i), s_pc, vt[i].e_pc);
            chk($sformatf("vec%0d_inst", i), s_inst, inst_of(vt[i].e_pc));
         end
      end
      redirect = 1'b0;

      // Zero-wait streaming: one instruction per cycle.
      do_reset();
      ack_mode = 0; ack_force = 1'b1; deq_ready = 1'b1;
      do_cycle();
      chk("stream_first_addr", s_addr, RESET_PC);
      chk("stream_first_valid", s_valid, 1'b0);
      for (int k = 0; k < 10; k++) begin
         do_cycle();
         chk($sformatf("stream%0d_valid", k), s_valid, 1'b1);
         chk($sformatf("stream%0d_pc", k), s_pc, RESET_PC + 32'(k * 4));
      end

      // Redirect while a 3-cycle fetch of 0x8 is outstanding.
      do_reset();
      ack_mode = 1; ack_lat = 3; deq_ready = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         do_cycle();
         if (s_req && s_addr == 32'h8) found = 1'b1;
      end
      chk("wait_reach_fetch8", found, 1'b1);
      redirect = 1'b1; redirect_pc = 32'h0000_0100;
      do_cycle();
      redirect = 1'b0;
      got_deq = 1'b0; got_addr = 1'b0; first_addr = 32'h0; first_pc = 32'h0;
      for (int k = 0; k < 60 && !got_deq; k++) begin
         do_cycle();
         if (s_req && s_addr != 32'h8 && !got_addr) begin
            got_addr = 1'b1; first_addr = s_addr;
         end
         if (s_valid) begin
            got_deq = 1'b1; first_pc = s_pc;
         end
      end
      chk("wait_redir_got_deq", got_deq, 1'b1);
      chk("wait_redir_next_addr", first_addr, 32'h0000_0100);
      chk("wait_redir_first_pc", first_pc, 32'h0000_0100);

      // Redirect together with an ack and a pop while two entries are queued.
      do_reset();
      ack_mode = 0; ack_force = 1'b1; deq_ready = 1'b0;
      do_cycle();
      do_cycle();
      deq_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
      do_cycle();
      chk("ackpop_redir_req", s_req, 1'b1);
      chk("ackpop_redir_valid_before", s_valid, 1'b1);
      redirect = 1'b0; deq_ready = 1'b0;
      do_cycle();
      chk("ackpop_redir_valid", s_valid, 1'b0);
      chk("ackpop_redir_addr", s_addr, 32'h0000_0200);

      // Reset while dropping a fetch.
      do_reset();
      ack_mode = 1; ack_lat = 3; deq_ready = 1'b1;
      do_cycle();
      do_cycle();
      redirect = 1'b1; redirect_pc = 32'h0000_0040;
      do_cycle();
      redirect = 1'b0; rst = 1'b1;
      do_cycle();
      chk("drop_rst_req", s_req, 1'b0);
      chk("drop_rst_valid", s_valid, 1'b0);
      rst = 1'b0;
      do_cycle();
      chk("drop_rst_first_req", s_req, 1'b1);
      chk("drop_rst_first_addr", s_addr, RESET_PC);
      got_deq = 1'b0; first_pc = 32'hDEAD_BEEF;
      for (int k = 0; k < 30 && !got_deq; k++) begin
         do_cycle();
         if (s_valid) begin
            got_deq = 1'b1; first_pc = s_pc;
         end
      end
      chk("drop_rst_first_deq_pc", first_pc, RESET_PC);

      // Random traffic against the model.
      do_reset();
      ack_mode = 2;
      for (int k = 0; k < 1200; k++) begin
         rst         = ($urandom_range(0, 199) == 0);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = $urandom();
         if ((k % 200) < 100) deq_ready = ($urandom_range(0, 3) != 0);
         else deq_ready = ($urandom_range(0, 3) == 0);
         do_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_prefetch_queue.md
INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of 2, at least 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have rst  in  1  synchronous active-high reset.
REQ-005 SHALL have redirect  in  1  flush the queue and restart fetch (branch or exception redirect).
REQ-006 SHALL have redirect_pc  in  32  new fetch address; bits [1:0] are ignored and treated as 00.
REQ-007 SHALL have imem_req  out  1  fetch request, held until acknowledged.
REQ-008 SHALL have imem_addr  out  32  word-aligned fetch address, stable while imem_req=1.
REQ-009 SHALL have imem_ack  in  1  fetch complete; meaningful only while imem_req=1.
REQ-010 SHALL have imem_rdata  in  32  instruction, valid with imem_ack.
REQ-011 SHALL have deq_valid  out  1  queue head holds a valid instruction.
REQ-012 SHALL have deq_pc  out  32  PC of the head entry.
REQ-013 SHALL have deq_inst  out  32  instruction of the head entry.
REQ-014 SHALL have deq_ready  in  1  consumer accepts the head this cycle; driven by the IF/ID register as NOT stall.

Function
REQ-015 SHALL run an FSM with three states: REQ (may issue a fetch), WAIT (fetch outstanding), DROP (an outstanding fetch is to be discarded).
REQ-016 SHALL assert imem_req in REQ only when count+1 <= DEPTH, and SHALL hold it in WAIT and DROP; otherwise imem_req=0.
REQ-017 SHALL allow imem_ack in the same cycle imem_req first rises (zero-wait memory), giving a sustained throughput of 1 instruction per cycle.
REQ-018 SHALL, on imem_ack outside DROP, write {fetch_pc, imem_rdata} at the tail, advance fetch_pc by 4 (modulo 2^32, so 0xFFFF_FFFC wraps to 0), and go to REQ.
REQ-019 SHALL, on imem_req without imem_ack, enter or remain in WAIT with imem_addr unchanged.
REQ-020 SHALL present an enqueued entry at the head with deq_valid=1 no earlier than the cycle after its imem_ack (1-cycle latency).
REQ-021 SHALL set deq_valid = (count != 0), and SHALL drive deq_pc and deq_inst from the head entry, registered and never combinational from imem_rdata.
REQ-022 SHALL pop the head on deq_valid && deq_ready, and SHALL allow a simultaneous push and pop, leaving count unchanged.
REQ-023 SHALL NOT issue a request that would overflow the queue; a push into a full queue is impossible by construction, and an assertion SHALL flag any such push.
REQ-024 SHALL, on redirect, clear count and pointers next cycle, load fetch_pc with {redirect_pc[31:2],2'b00}, and take priority over push and pop in that cycle.
REQ-025 SHALL handle redirect according to the fetch state: with no fetch outstanding, go to REQ; with a fetch outstanding and acked in the same cycle, discard the data and go to REQ; with a fetch outstanding and not acked, go to DROP.
REQ-026 SHALL, in DROP, discard the data on imem_ack and go to REQ; imem_addr stays at the old address until that ack.
REQ-027 SHALL treat a second redirect while in DROP as follows: latch the newer redirect_pc and stay in DROP.
REQ-028 SHALL drive deq_valid=0 in the cycle after any redirect.

Reset
REQ-029 SHALL, while rst=1, drive imem_req=0 and deq_valid=0.
REQ-030 SHALL, on reset, set count and pointers to 0, state to REQ, and fetch_pc to RESET_PC.
REQ-031 SHALL reset deq_pc and deq_inst to 0.
REQ-032 SHALL give rst priority over redirect.
REQ-033 SHALL, on rst asserted mid-fetch, abandon the outstanding fetch; the memory is reset by the same rst.
REQ-034 SHALL issue the first request, at RESET_PC, in the first cycle after rst deasserts.

Structure
REQ-035 SHALL place the state encoding (REQ/WAIT/DROP) and the default DEPTH and RESET_PC constants in the shared core package.
REQ-036 SHALL implement the storage as one sub-module, fetch_fifo: a synchronous FIFO with push, pop, clear, count, and a registered head.
REQ-037 SHALL keep the FSM and fetch_pc logic in inst_prefetch_queue.

Verification
REQ-038 SHALL cover zero-wait streaming: imem_ack tied to 1, deq_ready=1 -> after reset deq_pc = 0,4,8,... on consecutive cycles, deq_valid constant 1 from cycle 2.
REQ-039 SHALL cover fill with backpressure: deq_ready=0, ack always 1 -> exactly 4 requests, then imem_req=0; count=4; raising deq_ready drains PCs 0,4,8,12 in order.
REQ-040 SHALL cover redirect while WAIT: 3-cycle ack latency; redirect to 0x100 in cycle 1 of a fetch of 0x8 -> the ack data for 0x8 never appears, the next imem_addr is 0x100, and the first deq_pc is 0x100.
REQ-041 SHALL cover redirect with a simultaneous ack and pop: queue holding 2 entries -> the queue is empty next cycle, deq_valid=0, and the next imem_addr is the redirect target.
REQ-042 SHALL cover wrap and alignment: redirect_pc=0xFFFF_FFFE -> fetches 0xFFFF_FFFC, then 0x0000_0000.
REQ-043 SHALL cover reset mid-DROP: rst for 1 cycle -> imem_req=0 during reset, then the first imem_addr is RESET_PC and no stale entry is ever dequeued.
